counter_cmd_sequencer: RTL and testbench

- Command-side initiator for the mod-12 loadable up/down counter.
- Accepts LOAD/UP/DOWN/HOLD commands over a valid/ready interface and drives the counter's rst, load, mode and datain pins cycle by cycle.
- Keeps a cycle-aligned model of the expected count and, optionally, checks the counter's dataout against it.
- Idle hold is implemented by reloading the modelled value, because the counter has no enable.

---
 rtl/counter_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_counter_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_sequencer.sv
// Command-side initiator for a mod-MOD loadable up/down counter with a cycle-aligned count model.
// Define COUNTER_CMD_SEQ_CMP_EN to compare ctr_dataout against the model (sticky mismatch).
module counter_cmd_sequencer #(
    parameter int MOD   = 12,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             ctr_rst,
    output logic             ctr_load,
    output logic             ctr_mode,
    output logic [WIDTH-1:0] ctr_datain,
    input  logic [WIDTH-1:0] ctr_dataout,
    output logic [WIDTH-1:0] exp_count,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             load_err,
    output logic             mismatch
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN} state_t;

    state_t           state, state_nx;
    logic [1:0]       op, op_nx;
    logic [WIDTH-1:0] rem, rem_nx;
    logic [WIDTH-1:0] exp_nx, datain_nx;
    logic             load_nx, mode_nx, ready_nx, busy_nx, done_nx;
    logic             wrap_nx, load_err_nx, mismatch_nx;

    always_comb begin
        // The model steps on exactly the pins the counter samples at the same edge.
        if (ctr_rst)
            exp_nx = '0;
        else if (ctr_load)
            exp_nx = ctr_datain;
        else if (ctr_mode)
            exp_nx = (exp_count == MAX_VAL) ? '0 : exp_count + 1'b1;
        else
            exp_nx = (exp_count == '0) ? MAX_VAL : exp_count - 1'b1;
        wrap_nx = !ctr_rst && !ctr_load &&
                  (ctr_mode ? (exp_count == MAX_VAL) : (exp_count == '0));

        state_nx    = state;
        op_nx       = op;
        rem_nx      = rem;
        load_nx     = 1'b1;
        mode_nx     = 1'b0;
        datain_nx   = exp_nx;
        ready_nx    = 1'b0;
        busy_nx     = 1'b0;
        done_nx     = 1'b0;
        load_err_nx = 1'b0;

        unique case (state)
            S_INIT: begin
                state_nx = S_IDLE;
                ready_nx = 1'b1;
            end
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nx = S_RUN;
                    busy_nx  = 1'b1;
                    op_nx    = cmd_op;
                    rem_nx   = (cmd_arg == '0) ? '0 : cmd_arg - 1'b1;
                    unique case (cmd_op)
                        OP_LOAD: begin
                            rem_nx      = '0;
                            datain_nx   = (cmd_arg > MAX_VAL) ? MAX_VAL : cmd_arg;
                            load_err_nx = (cmd_arg > MAX_VAL);
                        end
                        OP_UP: begin
                            if (cmd_arg != '0) begin
                                load_nx = 1'b0;
                                mode_nx = 1'b1;
                            end
                        end
                        OP_DOWN: begin
                            if (cmd_arg != '0)
                                load_nx = 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    ready_nx = 1'b1;
                end
            end
            S_RUN: begin
                if (rem == '0) begin
                    state_nx = S_IDLE;
                    ready_nx = 1'b1;
                    done_nx  = 1'b1;
                end else begin
                    rem_nx  = rem - 1'b1;
                    busy_nx = 1'b1;
                    if (op == OP_UP) begin
                        load_nx = 1'b0;
                        mode_nx = 1'b1;
                    end else if (op == OP_DOWN) begin
                        load_nx = 1'b0;
                    end
                end
            end
            default: state_nx = S_INIT;
        endcase
    end

`ifdef COUNTER_CMD_SEQ_CMP_EN
    assign mismatch_nx = mismatch | ((state != S_INIT) && (ctr_dataout != exp_count));
`else
    logic unused_dataout;
    assign unused_dataout = ^ctr_dataout;
    assign mismatch_nx    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_INIT;
            op         <= OP_LOAD;
            rem        <= '0;
            ctr_rst    <= 1'b1;
            ctr_load   <= 1'b0;
            ctr_mode   <= 1'b0;
            ctr_datain <= '0;
            exp_count  <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
            load_err   <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            state      <= state_nx;
            op         <= op_nx;
            rem        <= rem_nx;
            ctr_rst    <= 1'b0;
            ctr_load   <= load_nx;
            ctr_mode   <= mode_nx;
            ctr_datain <= datain_nx;
            exp_count  <= exp_nx;
            cmd_ready  <= ready_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            wrap       <= wrap_nx;
            load_err   <= load_err_nx;
            mismatch   <= mismatch_nx;
        end
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Scoreboard bench: directed commands push expected results; a monitor pops them on done.
module tb_counter_cmd_sequencer;

    localparam int MOD   = 12;
    localparam int WIDTH = 4;
`ifdef COUNTER_CMD_SEQ_CMP_EN
    localparam int MM_ON = 1;
`else
    localparam int MM_ON = 0;
`endif
    localparam logic [1:0] LD = 2'b00, UP = 2'b01, DN = 2'b10, HD = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_arg = '0;
    logic             ctr_rst, ctr_load, ctr_mode;
    logic [WIDTH-1:0] ctr_datain, ctr_dataout, exp_count;
    logic             busy, done, wrap, load_err, mismatch;

    counter_cmd_sequencer #(.MOD(MOD), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .ctr_rst(ctr_rst), .ctr_load(ctr_load), .ctr_mode(ctr_mode), .ctr_datain(ctr_datain),
        .ctr_dataout(ctr_dataout), .exp_count(exp_count),
        .busy(busy), .done(done), .wrap(wrap), .load_err(load_err), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // Reference mod-12 counter attached to the sequencer's pins.
    logic [WIDTH-1:0] cnt;
    logic             force_en = 1'b0;
    logic [WIDTH-1:0] force_val = '0;
    always @(posedge clk) begin
        if (ctr_rst)       cnt <= '0;
        else if (ctr_load) cnt <= ctr_datain;
        else if (ctr_mode) cnt <= (cnt == 4'd11) ? 4'd0 : cnt + 4'd1;
        else               cnt <= (cnt == 4'd0) ? 4'd11 : cnt - 4'd1;
    end
    assign ctr_dataout = force_en ? force_val : cnt;

    typedef struct {
        int fin;
        int wraps;
        int lerrs;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   mm_exp = 0;
    int   mon_cyc = 0, mon_wr = 0, mon_le = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] arg);
        int t = 0;
        @(negedge clk);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd_ready stayed 0, expected 1");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_arg   = 4'($urandom);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] arg,
                         input int fin, input int wraps, input int lerrs, input int lat);
        exp_t e;
        e.fin = fin; e.wraps = wraps; e.lerrs = lerrs; e.lat = lat;
        sb.push_back(e);
        send(op, arg);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    // Monitor: samples just after the falling edge, once stimulus has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mon_cyc++;
                if (wrap)     mon_wr++;
                if (load_err) mon_le++;
                if ((cmd_ready || busy) && !force_en)
                    chk("align", int'(ctr_dataout), int'(exp_count));
                if (done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done: done=1, expected 0 at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("final_exp",  int'(exp_count),   e.fin);
                        chk("final_dout", int'(ctr_dataout), e.fin);
                        chk("wraps",      mon_wr,            e.wraps);
                        chk("load_errs",  mon_le,            e.lerrs);
                        chk("latency",    mon_cyc,           e.lat);
                        chk("mismatch",   int'(mismatch),    mm_exp);
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    mon_cyc = 0;
                    mon_wr  = 0;
                    mon_le  = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctr_rst",  int'(ctr_rst), 1);
        chk("rst_load",     int'(ctr_load), 0);
        chk("rst_mode",     int'(ctr_mode), 0);
        chk("rst_datain",   int'(ctr_datain), 0);
        chk("rst_exp",      int'(exp_count), 0);
        chk("rst_ready",    int'(cmd_ready), 0);
        chk("rst_busy",     int'(busy), 0);
        chk("rst_done",     int'(done), 0);
        chk("rst_wrap",     int'(wrap), 0);
        chk("rst_load_err", int'(load_err), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("init_ctr_rst", int'(ctr_rst), 1);
        chk("init_ready",   int'(cmd_ready), 0);
        @(negedge clk);
        chk("idle_ctr_rst", int'(ctr_rst), 0);
        chk("idle_ready",   int'(cmd_ready), 1);
        chk("idle_exp",     int'(exp_count), 0);
        chk("idle_dout",    int'(ctr_dataout), 0);

        //     op  arg   fin wr le lat
        issue(LD, 4'd9,   9, 0, 0, 2);
        issue(UP, 4'd4,   1, 1, 0, 5);
        issue(LD, 4'd2,   2, 0, 0, 2);
        issue(DN, 4'd3,  11, 1, 0, 4);
        issue(LD, 4'd14, 11, 0, 1, 2);
        issue(LD, 4'd7,   7, 0, 0, 2);
        issue(HD, 4'd5,   7, 0, 0, 6);
        issue(UP, 4'd0,   7, 0, 0, 2);
        issue(DN, 4'd15,  4, 1, 0, 16);
        issue(UP, 4'd15,  7, 1, 0, 16);
        issue(LD, 4'd11, 11, 0, 0, 2);
        issue(UP, 4'd1,   0, 1, 0, 2);
        issue(DN, 4'd1,  11, 1, 0, 2);
        issue(HD, 4'd0,  11, 0, 0, 2);
        issue(LD, 4'd12, 11, 0, 1, 2);
        issue(LD, 4'd0,   0, 0, 0, 2);
        issue(DN, 4'd12,  0, 1, 0, 13);
        issue(LD, 4'd15, 11, 0, 1, 2);
        drain();

        // Corrupt the counter output for one cycle while the model holds 4.
        issue(LD, 4'd4, 4, 0, 0, 2);
        issue(HD, 4'd6, 4, 0, 0, 7);
        @(posedge clk);
        #1;
        force_en  = 1'b1;
        force_val = 4'd5;
        @(posedge clk);
        #1;
        force_en = 1'b0;
        mm_exp   = MM_ON;
        @(negedge clk);
        chk("mismatch_set", int'(mismatch), MM_ON);
        drain();
        @(negedge clk);
        chk("mismatch_sticky", int'(mismatch), MM_ON);

        // Abort UP 8 with reset after three steps.
        issue(LD, 4'd0, 0, 0, 0, 2);
        send(UP, 4'd8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_exp", int'(exp_count), 3);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mm_exp = 0;
        chk("abort_ctr_rst",  int'(ctr_rst), 1);
        chk("abort_busy",     int'(busy), 0);
        chk("abort_done",     int'(done), 0);
        chk("abort_ready",    int'(cmd_ready), 0);
        chk("abort_exp",      int'(exp_count), 0);
        chk("abort_mismatch", int'(mismatch), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reinit_ctr_rst", int'(ctr_rst), 1);
        @(negedge clk);
        chk("restart_exp",   int'(exp_count), 0);
        chk("restart_dout",  int'(ctr_dataout), 0);
        chk("restart_ready", int'(cmd_ready), 1);
        issue(UP, 4'd3, 3, 0, 0, 4);
        drain();
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
